// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential, handshaked binary-to-BCD converter using the double-dabble
// algorithm. It performs one shift/add-3 step per clock, so a W-bit word takes
// W cycles. With SIGNED=1 the input is two's complement: the magnitude is
// converted and the sign is reported separately. The result also carries an
// overflow flag and a count of significant digits, which the display logic
// uses for leading-zero blanking.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   an input word is offered
//   in_ready   the converter can accept a word this cycle
//   in_bin     binary input, W bits
//   out_valid  a result is held on the out_* ports
//   out_ready  the consumer takes the result this cycle
//   out_bcd    {..., hundreds, tens, ones}, 4 bits per digit
//   out_neg    the input was negative (always 0 when SIGNED=0)
//   out_ndig   number of significant digits, 1..DIGITS (a value of 0 gives 1)
//   out_ovf    magnitude >= 10**DIGITS; out_bcd holds magnitude mod 10**DIGITS
module bin2bcd_seq #(
  parameter int W      = 18,
  parameter int DIGITS = 6,
  parameter int SIGNED = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_bin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          out_bcd,
  output logic                         out_neg,
  output logic [$clog2(DIGITS+1)-1:0]  out_ndig,
  output logic                         out_ovf
);

  localparam int BW  = 4 * DIGITS;
  localparam int NDW = $clog2(DIGITS + 1);
  localparam int CW  = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [W-1:0]    bin_p0;   // remaining magnitude bits, MSB shifts out first
  logic [BW-1:0]   bcd_p0;   // BCD accumulator
  logic            ovf_p0;   // sticky: a 1 was shifted out of the top digit
  logic            neg_p0;
  logic [CW-1:0]   cnt;

  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_nxt;
  logic [W-1:0]    bin_nxt;
  logic            ovf_nxt;
  logic            accept;

  // Add 3 to every digit that is 5 or more, so the following doubling carries
  // correctly into the next decimal digit.
  function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int d = 0; d < DIGITS; d++) begin
      if (b[4*d +: 4] >= 4'd5) r[4*d +: 4] = b[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Index of the highest nonzero digit plus one; an all-zero value gives 1.
  function automatic logic [NDW-1:0] sig_digits(input logic [BW-1:0] b);
    logic [NDW-1:0] n;
    n = NDW'(1);
    for (int d = 0; d < DIGITS; d++) begin
      if (b[4*d +: 4] != 4'd0) n = NDW'(d + 1);
    end
    return n;
  endfunction

  // The negated most-negative value is 2^(W-1). That still fits in W bits
  // once it is treated as unsigned.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    logic signed [W-1:0] s;
    s = signed'(v);
    if (SIGNED != 0 && s < 0) return unsigned'(-s);
    return v;
  endfunction

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  assign bcd_adj            = add3_all(bcd_p0);
  assign {bcd_nxt, bin_nxt} = {bcd_adj[BW-2:0], bin_p0, 1'b0};
  assign ovf_nxt            = ovf_p0 | bcd_adj[BW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_p0    <= '0;
      bcd_p0    <= '0;
      ovf_p0    <= 1'b0;
      neg_p0    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_neg   <= 1'b0;
      out_ndig  <= NDW'(1);
      out_ovf   <= 1'b0;
    end else begin
      // Accept: from IDLE, or from DONE while the current result retires on
      // the same edge.
      if (accept) begin
        bin_p0 <= magnitude(in_bin);
        neg_p0 <= (SIGNED != 0) && in_bin[W-1];
        bcd_p0 <= '0;
        ovf_p0 <= 1'b0;
        cnt    <= '0;
      end
      case (state)
        IDLE: begin
          if (accept) state <= SHIFT;
        end
        // Shift stage: one double-dabble step per cycle. The last step loads
        // every output on the same edge.
        SHIFT: begin
          bcd_p0 <= bcd_nxt;
          bin_p0 <= bin_nxt;
          ovf_p0 <= ovf_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_bcd   <= bcd_nxt;
            out_ovf   <= ovf_nxt;
            out_neg   <= neg_p0;
            out_ndig  <= sig_digits(bcd_nxt);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        // Result stage: hold the outputs until the consumer takes them.
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? SHIFT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance a: W=18, DIGITS=6, unsigned
  logic        a_in_valid, a_in_ready, a_valid, a_out_ready, a_neg, a_ovf;
  logic [17:0] a_in_bin;
  logic [23:0] a_bcd;
  logic [2:0]  a_ndig;

  // Instance b: W=8, DIGITS=3, signed
  logic        b_in_valid, b_in_ready, b_valid, b_out_ready, b_neg, b_ovf;
  logic [7:0]  b_in_bin;
  logic [11:0] b_bcd;
  logic [1:0]  b_ndig;

  // Instance c: W=10, DIGITS=3, unsigned (overflow path)
  logic        c_in_valid, c_in_ready, c_valid, c_out_ready, c_neg, c_ovf;
  logic [9:0]  c_in_bin;
  logic [11:0] c_bcd;
  logic [1:0]  c_ndig;

  bin2bcd_seq #(.W(18), .DIGITS(6), .SIGNED(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bin(a_in_bin),
    .out_valid(a_valid), .out_ready(a_out_ready), .out_bcd(a_bcd), .out_neg(a_neg),
    .out_ndig(a_ndig), .out_ovf(a_ovf));

  bin2bcd_seq #(.W(8), .DIGITS(3), .SIGNED(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bin(b_in_bin),
    .out_valid(b_valid), .out_ready(b_out_ready), .out_bcd(b_bcd), .out_neg(b_neg),
    .out_ndig(b_ndig), .out_ovf(b_ovf));

  bin2bcd_seq #(.W(10), .DIGITS(3), .SIGNED(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_bin(c_in_bin),
    .out_valid(c_valid), .out_ready(c_out_ready), .out_bcd(c_bcd), .out_neg(c_neg),
    .out_ndig(c_ndig), .out_ovf(c_ovf));

  // Decimal reference model for the scoreboard.
  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int ref_ndig(input int unsigned v);
    int n;
    int unsigned x;
    n = 1;
    x = v;
    for (int d = 1; d <= 6; d++) begin
      if (x != 0) n = d;
      x = x / 10;
    end
    return n;
  endfunction

  // Stimulus drivers: offer one word, then count the edges until out_valid.
  task automatic run_a(input logic [17:0] v, output int lat);
    @(negedge clk); a_in_valid = 1'b1; a_in_bin = v;
    @(negedge clk); a_in_valid = 1'b0;
    lat = 0;
    while (!a_valid && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic run_b(input logic [7:0] v, output int lat);
    @(negedge clk); b_in_valid = 1'b1; b_in_bin = v;
    @(negedge clk); b_in_valid = 1'b0;
    lat = 0;
    while (!b_valid && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic run_c(input logic [9:0] v, output int lat);
    @(negedge clk); c_in_valid = 1'b1; c_in_bin = v;
    @(negedge clk); c_in_valid = 1'b0;
    lat = 0;
    while (!c_valid && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    if (a_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", a_valid); n_fail++; end n_cmp++;
    if (a_bcd !== 24'h0) begin $display("FAIL rst_bcd: got %h want 0", a_bcd); n_fail++; end n_cmp++;
    if (a_neg !== 1'b0) begin $display("FAIL rst_neg: got %b want 0", a_neg); n_fail++; end n_cmp++;
    if (a_ndig !== 3'd1) begin $display("FAIL rst_ndig: got %0d want 1", a_ndig); n_fail++; end n_cmp++;
    if (a_ovf !== 1'b0) begin $display("FAIL rst_ovf: got %b want 0", a_ovf); n_fail++; end n_cmp++;
    if (a_in_ready !== 1'b1) begin $display("FAIL rst_in_ready: got %b want 1", a_in_ready); n_fail++; end n_cmp++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_max;
    int lat;
    run_a(18'd262143, lat);
    if (lat !== 18) begin $display("FAIL max_latency: got %0d want 18", lat); n_fail++; end n_cmp++;
    if (a_bcd !== 24'h262143) begin $display("FAIL max_bcd: got %h want 262143", a_bcd); n_fail++; end n_cmp++;
    if (a_ndig !== 3'd6) begin $display("FAIL max_ndig: got %0d want 6", a_ndig); n_fail++; end n_cmp++;
    if (a_ovf !== 1'b0) begin $display("FAIL max_ovf: got %b want 0", a_ovf); n_fail++; end n_cmp++;
    if (a_neg !== 1'b0) begin $display("FAIL max_neg: got %b want 0", a_neg); n_fail++; end n_cmp++;
  endtask

  task automatic test_zero_1000;
    int lat;
    run_a(18'd0, lat);
    if (a_bcd !== 24'h0) begin $display("FAIL zero_bcd: got %h want 0", a_bcd); n_fail++; end n_cmp++;
    if (a_ndig !== 3'd1) begin $display("FAIL zero_ndig: got %0d want 1", a_ndig); n_fail++; end n_cmp++;
    run_a(18'd1000, lat);
    if (lat !== 18) begin $display("FAIL k_latency: got %0d want 18", lat); n_fail++; end n_cmp++;
    if (a_bcd !== 24'h001000) begin $display("FAIL k_bcd: got %h want 001000", a_bcd); n_fail++; end n_cmp++;
    if (a_ndig !== 3'd4) begin $display("FAIL k_ndig: got %0d want 4", a_ndig); n_fail++; end n_cmp++;
    @(negedge clk);
    if (a_valid !== 1'b0) begin $display("FAIL k_retire: got %b want 0", a_valid); n_fail++; end n_cmp++;
  endtask

  task automatic test_signed;
    int lat;
    run_b(8'h80, lat);
    if (lat !== 8) begin $display("FAIL s80_latency: got %0d want 8", lat); n_fail++; end n_cmp++;
    if (b_neg !== 1'b1) begin $display("FAIL s80_neg: got %b want 1", b_neg); n_fail++; end n_cmp++;
    if (b_bcd !== 12'h128) begin $display("FAIL s80_bcd: got %h want 128", b_bcd); n_fail++; end n_cmp++;
    if (b_ndig !== 2'd3) begin $display("FAIL s80_ndig: got %0d want 3", b_ndig); n_fail++; end n_cmp++;
    run_b(8'hFF, lat);
    if (b_neg !== 1'b1) begin $display("FAIL sff_neg: got %b want 1", b_neg); n_fail++; end n_cmp++;
    if (b_bcd !== 12'h001) begin $display("FAIL sff_bcd: got %h want 001", b_bcd); n_fail++; end n_cmp++;
    if (b_ndig !== 2'd1) begin $display("FAIL sff_ndig: got %0d want 1", b_ndig); n_fail++; end n_cmp++;
    run_b(8'h7F, lat);
    if (b_neg !== 1'b0) begin $display("FAIL s7f_neg: got %b want 0", b_neg); n_fail++; end n_cmp++;
    if (b_bcd !== 12'h127) begin $display("FAIL s7f_bcd: got %h want 127", b_bcd); n_fail++; end n_cmp++;
    if (b_ovf !== 1'b0) begin $display("FAIL s7f_ovf: got %b want 0", b_ovf); n_fail++; end n_cmp++;
  endtask

  task automatic test_ovf;
    int lat;
    run_c(10'd1023, lat);
    if (lat !== 10) begin $display("FAIL ovf_latency: got %0d want 10", lat); n_fail++; end n_cmp++;
    if (c_ovf !== 1'b1) begin $display("FAIL ovf_flag: got %b want 1", c_ovf); n_fail++; end n_cmp++;
    if (c_bcd !== 12'h023) begin $display("FAIL ovf_bcd: got %h want 023", c_bcd); n_fail++; end n_cmp++;
    if (c_ndig !== 2'd2) begin $display("FAIL ovf_ndig: got %0d want 2", c_ndig); n_fail++; end n_cmp++;
    run_c(10'd999, lat);
    if (c_ovf !== 1'b0) begin $display("FAIL ovf_clear: got %b want 0", c_ovf); n_fail++; end n_cmp++;
    if (c_bcd !== 12'h999) begin $display("FAIL ovf_999_bcd: got %h want 999", c_bcd); n_fail++; end n_cmp++;
    if (c_ndig !== 2'd3) begin $display("FAIL ovf_999_ndig: got %0d want 3", c_ndig); n_fail++; end n_cmp++;
  endtask

  task automatic test_back_to_back;
    int lat;
    a_out_ready = 1'b0;
    run_a(18'd54321, lat);
    if (lat !== 18) begin $display("FAIL bp_latency: got %0d want 18", lat); n_fail++; end n_cmp++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); a_in_valid = 1'b1; a_in_bin = 18'd777; #1;
      if (a_valid !== 1'b1) begin $display("FAIL bp_hold_valid: got %b want 1", a_valid); n_fail++; end n_cmp++;
      if (a_bcd !== 24'h054321) begin $display("FAIL bp_hold_bcd: got %h want 054321", a_bcd); n_fail++; end n_cmp++;
      if (a_ndig !== 3'd5) begin $display("FAIL bp_hold_ndig: got %0d want 5", a_ndig); n_fail++; end n_cmp++;
      if (a_in_ready !== 1'b0) begin $display("FAIL bp_in_ready: got %b want 0", a_in_ready); n_fail++; end n_cmp++;
    end
    @(negedge clk); a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_bin = 18'd777; #1;
    if (a_in_ready !== 1'b1) begin $display("FAIL b2b_in_ready: got %b want 1", a_in_ready); n_fail++; end n_cmp++;
    @(negedge clk); a_in_valid = 1'b0; #1;
    if (a_valid !== 1'b0) begin $display("FAIL b2b_retired: got %b want 0", a_valid); n_fail++; end n_cmp++;
    if (a_in_ready !== 1'b0) begin $display("FAIL b2b_busy: got %b want 0", a_in_ready); n_fail++; end n_cmp++;
    lat = 0;
    while (!a_valid && lat < 100) begin @(negedge clk); lat++; end
    if (lat !== 18) begin $display("FAIL b2b_latency: got %0d want 18", lat); n_fail++; end n_cmp++;
    if (a_bcd !== 24'h000777) begin $display("FAIL b2b_bcd: got %h want 000777", a_bcd); n_fail++; end n_cmp++;
    if (a_ndig !== 3'd3) begin $display("FAIL b2b_ndig: got %0d want 3", a_ndig); n_fail++; end n_cmp++;
  endtask

  task automatic test_reset_mid;
    int lat;
    int spurious;
    @(negedge clk); a_in_valid = 1'b1; a_in_bin = 18'd123456;
    @(negedge clk); a_in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (a_valid !== 1'b0) begin $display("FAIL mid_rst_valid: got %b want 0", a_valid); n_fail++; end n_cmp++;
    if (a_bcd !== 24'h0) begin $display("FAIL mid_rst_bcd: got %h want 0", a_bcd); n_fail++; end n_cmp++;
    if (a_ndig !== 3'd1) begin $display("FAIL mid_rst_ndig: got %0d want 1", a_ndig); n_fail++; end n_cmp++;
    if (a_in_ready !== 1'b1) begin $display("FAIL mid_rst_in_ready: got %b want 1", a_in_ready); n_fail++; end n_cmp++;
    @(negedge clk); rst_n = 1'b1;
    spurious = 0;
    repeat (30) begin @(negedge clk); if (a_valid) spurious++; end
    if (spurious !== 0) begin $display("FAIL mid_no_emit: got %0d valid cycles want 0", spurious); n_fail++; end n_cmp++;
    run_a(18'd4095, lat);
    if (lat !== 18) begin $display("FAIL mid_fresh_latency: got %0d want 18", lat); n_fail++; end n_cmp++;
    if (a_bcd !== 24'h004095) begin $display("FAIL mid_fresh_bcd: got %h want 004095", a_bcd); n_fail++; end n_cmp++;
    if (a_ndig !== 3'd4) begin $display("FAIL mid_fresh_ndig: got %0d want 4", a_ndig); n_fail++; end n_cmp++;
  endtask

  task automatic test_random;
    logic [17:0] q[$];
    logic [17:0] v;
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < 30 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      a_in_valid = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 5))
        0: a_in_bin = 18'd0;
        1: a_in_bin = 18'd262143;
        2: a_in_bin = 18'd99999;
        default: a_in_bin = 18'($urandom_range(0, 262143));
      endcase
      a_out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (a_valid && a_out_ready) begin
        if (q.size() == 0) begin
          $display("FAIL rnd_unexpected: got valid result %h want none pending", a_bcd); n_fail++; n_cmp++;
        end else begin
          v = q.pop_front();
          got++;
          if (a_bcd !== ref_bcd(v)) begin $display("FAIL rnd_bcd(%0d): got %h want %h", v, a_bcd, ref_bcd(v)); n_fail++; end n_cmp++;
          if (a_ndig !== 3'(ref_ndig(v))) begin $display("FAIL rnd_ndig(%0d): got %0d want %0d", v, a_ndig, ref_ndig(v)); n_fail++; end n_cmp++;
          if (a_ovf !== 1'b0) begin $display("FAIL rnd_ovf(%0d): got %b want 0", v, a_ovf); n_fail++; end n_cmp++;
        end
      end
      if (a_in_valid && a_in_ready) q.push_back(a_in_bin);
    end
    if (got < 30) begin $display("FAIL rnd_timeout: got %0d results want 30", got); n_fail++; end n_cmp++;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    repeat (25) @(negedge clk);
  endtask

  initial begin
    a_in_valid = 1'b0; a_in_bin = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_bin = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_bin = '0; c_out_ready = 1'b1;
    test_reset();
    test_max();
    test_zero_1000();
    test_signed();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
